irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of interrupt sources (1..16).
REQ-002 SHALL have parameter VEC_BASE, default 10'h380, vector address of source 0.
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port irq_in  input  NSRC  raw source lines, synchronous to clk.
REQ-006 SHALL have port mask_we  input  1  mask register write enable.
REQ-007 SHALL have port mask_wd  input  NSRC  mask write data (1 = source enabled).
REQ-008 SHALL have port ack  input  1  CPU has taken the vector jump.
REQ-009 SHALL have port iret  input  1  CPU executes return-from-interrupt.
REQ-010 SHALL have port pc_in  input  10  CPU next-PC, saved at ack.
REQ-011 SHALL have port irq_req  output  1  interrupt request to CPU.
REQ-012 SHALL have port irq_vec  output  10  handler address for the current source.
REQ-013 SHALL have port ret_pc  output  10  saved return PC.
REQ-014 SHALL have port mask  output  NSRC  current mask register.
REQ-015 SHALL have port pending  output  NSRC  latched pending events.
REQ-016 SHALL have port in_service  output  NSRC  one-hot source being serviced, 0 when none.

Function
REQ-017 SHALL register irq_in each cycle; pending[i] SHALL set on a rising edge (previous 0, current 1), visible one cycle after the edge.
REQ-018 eligible = pending & mask; selected source SHALL be the lowest set index of eligible (one-hot, eligible & -eligible).
REQ-019 FSM states IDLE, REQ, SVC; irq_req SHALL be 1 exactly in REQ.
REQ-020 IDLE -> REQ when eligible != 0; the selected index SHALL be latched as cur on that edge.
REQ-021 In REQ, irq_vec SHALL be VEC_BASE + 4*cur (mod 1024), stable until ack; mask or pending changes SHALL NOT alter cur.
REQ-022 REQ -> SVC on ack: pending[cur] cleared, ret_pc <= pc_in, in_service <= one-hot(cur).
REQ-023 SVC -> IDLE on iret: in_service <= 0; no nesting, and new requests wait until IDLE.
REQ-024 ack outside REQ and iret outside SVC SHALL be ignored; when both are asserted, only the one valid for the current state acts.
REQ-025 A new rising edge on source cur in the ack cycle SHALL win: pending[cur] remains 1.
REQ-026 mask_we SHALL load mask_wd on the next edge; the new mask affects eligibility from the following cycle and is writable in any state.
REQ-027 Latency: irq_in edge sampled at edge n -> pending at n -> irq_req high after edge n+1 (IDLE, enabled source).
REQ-028 Masked pending bits SHALL be retained and become eligible when unmasked.
REQ-029 irq_vec and ret_pc SHALL hold their last values outside REQ/SVC.

Reset
REQ-030 On reset = 0, all state SHALL clear immediately: FSM IDLE, mask 0, pending 0, edge history 0, cur 0, ret_pc 0, in_service 0, irq_req 0, irq_vec VEC_BASE.
REQ-031 Reset asserted in REQ or SVC SHALL abandon the service with no residual pending bit; an irq_in held at 1 across reset release SHALL NOT generate an event.

Structure
REQ-032 Package SHALL hold PC_W = 10, VEC_STRIDE = 4, the state encoding, and the default VEC_BASE.
REQ-033 The priority one-hot selection SHALL reuse the existing max_priority_bit sub-module (WIDTH = NSRC), followed by a local one-hot-to-index encoder.

Verification
REQ-034 mask=8'hFF, pulse irq_in[3] -> irq_req high 2 cycles after the pulse, irq_vec=10'h38C; ack with pc_in=10'h045 -> ret_pc=10'h045, in_service=8'h08, pending[3]=0.
REQ-035 Simultaneous edges on sources 5 and 2 -> 2 serviced first (vec 10'h388); after iret -> source 5 requested (vec 10'h394).
REQ-036 mask=8'h00, pulse irq_in[1] -> pending=8'h02, irq_req stays 0; write mask=8'h02 -> irq_req high within 2 cycles.
REQ-037 In SVC, pulse irq_in[0] -> no irq_req until iret; then request source 0; ack and iret in the same cycle during REQ -> only ack acts.
REQ-038 Assert reset in SVC with pending=8'h10 -> all outputs reset; irq_in[4] held at 1 through reset release -> no request.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: PC/vector width, vector
// spacing, FSM state encoding, default vector base and the vector address
// helper.
package irq_controller_pkg;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned VEC_STRIDE = 4;

    localparam logic [PC_W-1:0] DEFAULT_VEC_BASE = 10'h380;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_e;

    // Handler address for a source index; wraps modulo 2**PC_W.
    function automatic logic [PC_W-1:0] vec_addr(input logic [PC_W-1:0] base,
                                                 input logic [PC_W-1:0] idx);
        return base + idx * PC_W'(VEC_STRIDE);
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side handshake of the interrupt controller.
//   irq_req : controller -> CPU, interrupt request
//   irq_vec : controller -> CPU, handler address of the current source
//   ret_pc  : controller -> CPU, PC saved when the vector was taken
//   ack     : CPU -> controller, vector jump taken
//   iret    : CPU -> controller, return-from-interrupt executed
//   pc_in   : CPU -> controller, next PC, captured on ack
interface irq_controller_if;
    import irq_controller_pkg::*;

    logic            irq_req;
    logic [PC_W-1:0] irq_vec;
    logic [PC_W-1:0] ret_pc;
    logic            ack;
    logic            iret;
    logic [PC_W-1:0] pc_in;

    // CPU side
    modport master (
        input  irq_req,
        input  irq_vec,
        input  ret_pc,
        output ack,
        output iret,
        output pc_in
    );

    // Controller side
    modport slave (
        output irq_req,
        output irq_vec,
        output ret_pc,
        input  ack,
        input  iret,
        input  pc_in
    );

endinterface

// File: rtl/max_priority_bit.sv
// Fixed-priority one-hot selector: keeps only the lowest set bit of din
// (bit 0 has the highest priority). dout is zero when din is zero.
//   din  : request vector
//   dout : one-hot grant (din & -din)
module max_priority_bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din & (~din + WIDTH'(1));
    end

endmodule

// File: rtl/irq_controller.sv
// Single-level interrupt controller. Rising edges on irq_in latch pending
// bits; the lowest-index pending and enabled source is requested from the
// CPU, acknowledged (return PC saved) and retired by iret. No nesting.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low
//   cpu        : CPU handshake (irq_req, irq_vec, ret_pc, ack, iret, pc_in)
//   irq_in     : raw source lines, synchronous to clk
//   mask_we    : mask register write enable
//   mask_wd    : mask write data (1 = source enabled)
//   mask       : current mask register
//   pending    : latched pending events
//   in_service : one-hot source being serviced, 0 when none
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned     NSRC     = 8,
    parameter logic [PC_W-1:0] VEC_BASE = DEFAULT_VEC_BASE
) (
    input  logic            clk,
    input  logic            reset,
    irq_controller_if.slave cpu,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wd,
    output logic [NSRC-1:0] mask,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service
);

    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    irq_state_e      state_q,      state_d;
    logic [NSRC-1:0] irq_prev_q,   irq_prev_d;
    logic            armed_q,      armed_d;
    logic [NSRC-1:0] mask_q,       mask_d;
    logic [NSRC-1:0] pending_q,    pending_d;
    logic [IDX_W-1:0] cur_q,       cur_d;
    logic [PC_W-1:0] vec_q,        vec_d;
    logic [PC_W-1:0] ret_pc_q,     ret_pc_d;
    logic [NSRC-1:0] in_service_q, in_service_d;

    logic [NSRC-1:0]  rise;
    logic [NSRC-1:0]  eligible;
    logic [NSRC-1:0]  sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic [NSRC-1:0]  cur_onehot;

    // The edge detector is disarmed for the first cycle after reset so a
    // line already high at release is absorbed into the history instead of
    // being seen as a 0->1 transition.
    always_comb begin
        rise = armed_q ? (irq_in & ~irq_prev_q) : '0;
    end

    always_comb begin
        eligible = pending_q & mask_q;
    end

    max_priority_bit #(
        .WIDTH(NSRC)
    ) u_prio (
        .din (eligible),
        .dout(sel_onehot)
    );

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cur_onehot = NSRC'(1) << cur_q;
    end

    always_comb begin
        state_d      = state_q;
        irq_prev_d   = irq_in;
        armed_d      = 1'b1;
        mask_d       = mask_we ? mask_wd : mask_q;
        pending_d    = pending_q;
        cur_d        = cur_q;
        vec_d        = vec_q;
        ret_pc_d     = ret_pc_q;
        in_service_d = in_service_q;

        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d = ST_REQ;
                    cur_d   = sel_idx;
                    vec_d   = vec_addr(VEC_BASE, PC_W'(sel_idx));
                end
            end
            ST_REQ: begin
                if (cpu.ack) begin
                    state_d      = ST_SVC;
                    pending_d    = pending_d & ~cur_onehot;
                    ret_pc_d     = cpu.pc_in;
                    in_service_d = cur_onehot;
                end
            end
            ST_SVC: begin
                if (cpu.iret) begin
                    state_d      = ST_IDLE;
                    in_service_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New edges are merged after the ack clear so an edge on the source
        // being acknowledged in the same cycle stays pending.
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            irq_prev_q   <= '0;
            armed_q      <= 1'b0;
            mask_q       <= '0;
            pending_q    <= '0;
            cur_q        <= '0;
            vec_q        <= VEC_BASE;
            ret_pc_q     <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_prev_d;
            armed_q      <= armed_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            cur_q        <= cur_d;
            vec_q        <= vec_d;
            ret_pc_q     <= ret_pc_d;
            in_service_q <= in_service_d;
        end
    end

    assign cpu.irq_req = (state_q == ST_REQ);
    assign cpu.irq_vec = vec_q;
    assign cpu.ret_pc  = ret_pc_q;
    assign mask        = mask_q;
    assign pending     = pending_q;
    assign in_service  = in_service_q;

endmodule
